mc_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the existing CPU datapath (PC, IM, GPR, EXT, ALU, DM, select muxes) for a multi-cycle variant of the processor.
- Replaces the single-cycle combinational decoder.
- Issues per-state strobes and mux selects.
- Stalls on a data-memory ready handshake.
- Traps on illegal opcodes.

---
 rtl/mc_ctrl_if.sv | 37 +++
 rtl/mc_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle controller and the CPU datapath.
// The master side is the controller; the slave side is the datapath.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] aluop;
    logic [1:0] s_num_write;
    logic [1:0] s_ext;
    logic       s_a;
    logic       s_b;
    logic [1:0] s_data_write;
    logic [1:0] s_npc;
    logic [2:0] state;
    logic       instr_done;
    logic       halt;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_read, mem_write, aluop,
               s_num_write, s_ext, s_a, s_b, s_data_write, s_npc,
               state, instr_done, halt
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_read, mem_write, aluop,
               s_num_write, s_ext, s_a, s_b, s_data_write, s_npc,
               state, instr_done, halt
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM sequencing the CPU datapath.
//
// state  | meaning
// FETCH  | load IR from instruction memory
// DECODE | legality check; jumps complete here
// EXEC   | ALU operation; beq completes here
// MEM    | data-memory access, stalls on mem_ready
// WB     | register write-back, PC advance
// HALT   | illegal opcode or memory timeout, held until reset
module mc_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic      clock,
    input  logic      reset,
    mc_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_HALT   = 3'b111
    } state_e;

    typedef enum logic [3:0] {
        C_ILL, C_RALU, C_JR, C_ADDI, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL
    } cls_e;

    localparam int CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MEM_WAIT_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    cls_e       cls;
    logic [3:0] ex_aluop;
    logic [1:0] ex_s_ext;
    logic       ex_s_a;
    logic       ex_s_b;

    assign cnt_inc = cnt_q + 1'b1;

    // Instruction class and the ALU/operand selects used from EXEC onward.
    always_comb begin
        cls      = C_ILL;
        ex_aluop = 4'b0000;
        ex_s_ext = 2'b00;
        ex_s_a   = 1'b1;
        ex_s_b   = 1'b1;
        case (bus.op)
            6'b000000: begin
                ex_s_b = 1'b0;
                case (bus.funct)
                    6'b100000: begin cls = C_RALU; ex_aluop = 4'b0000; end
                    6'b100010: begin cls = C_RALU; ex_aluop = 4'b0001; end
                    6'b100100: begin cls = C_RALU; ex_aluop = 4'b0010; end
                    6'b100101: begin cls = C_RALU; ex_aluop = 4'b0011; end
                    6'b101010: begin cls = C_RALU; ex_aluop = 4'b0100; end
                    6'b001000: cls = C_JR;
                    default:   cls = C_ILL;
                endcase
            end
            6'b001000: begin cls = C_ADDI; ex_s_ext = 2'b01; end
            6'b001101: begin cls = C_ORI;  ex_aluop = 4'b0011; end
            6'b001111: begin cls = C_LUI;  ex_aluop = 4'b0101; ex_s_ext = 2'b10; end
            6'b100011: begin cls = C_LW;   ex_s_ext = 2'b01; end
            6'b101011: begin cls = C_SW;   ex_s_ext = 2'b01; end
            6'b000100: begin
                cls      = C_BEQ;
                ex_s_a   = 1'b0;
                ex_s_ext = 2'b11;
            end
            6'b000010: cls = C_J;
            6'b000011: cls = C_JAL;
            default:   cls = C_ILL;
        endcase
    end

    // State and MEM wait-counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and per-state strobes/selects. ALU selects stay applied
    // through MEM and WB because the datapath has no ALU output register.
    always_comb begin
        state_d          = state_q;
        cnt_d            = '0;
        bus.pc_write     = 1'b0;
        bus.ir_write     = 1'b0;
        bus.reg_write    = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.aluop        = 4'b0000;
        bus.s_num_write  = 2'b00;
        bus.s_ext        = 2'b00;
        bus.s_a          = 1'b0;
        bus.s_b          = 1'b0;
        bus.s_data_write = 2'b00;
        bus.s_npc        = 2'b00;
        bus.instr_done   = 1'b0;
        bus.halt         = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.ir_write = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                case (cls)
                    C_ILL: state_d = S_HALT;
                    C_J, C_JAL, C_JR: begin
                        bus.pc_write   = 1'b1;
                        bus.instr_done = 1'b1;
                        bus.s_npc      = (cls == C_JR) ? 2'b10 : 2'b01;
                        if (cls == C_JAL) begin
                            bus.reg_write   = 1'b1;
                            bus.s_num_write = 2'b10;
                        end
                        state_d = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC, S_MEM, S_WB: begin
                bus.aluop = ex_aluop;
                bus.s_ext = ex_s_ext;
                bus.s_a   = ex_s_a;
                bus.s_b   = ex_s_b;
                if (state_q == S_EXEC) begin
                    if (cls == C_BEQ) begin
                        bus.pc_write   = 1'b1;
                        bus.instr_done = 1'b1;
                        bus.s_npc      = bus.zero ? 2'b11 : 2'b00;
                        state_d        = S_FETCH;
                    end else if (cls == C_LW || cls == C_SW) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (state_q == S_MEM) begin
                    if (bus.mem_ready) begin
                        if (cls == C_SW) begin
                            bus.mem_write  = 1'b1;
                            bus.pc_write   = 1'b1;
                            bus.instr_done = 1'b1;
                            state_d        = S_FETCH;
                        end else begin
                            bus.mem_read = 1'b1;
                            state_d      = S_WB;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        // The cycle whose stall count reaches the limit is the
                        // exit cycle and drives no memory strobe.
                        if (MEM_WAIT_MAX != 0 && cnt_inc == MAX_W) begin
                            state_d = S_HALT;
                        end else begin
                            bus.mem_read  = (cls != C_SW);
                            bus.mem_write = (cls == C_SW);
                        end
                    end
                end else begin
                    bus.reg_write    = 1'b1;
                    bus.pc_write     = 1'b1;
                    bus.instr_done   = 1'b1;
                    bus.s_num_write  = (cls == C_RALU) ? 2'b01 : 2'b00;
                    bus.s_data_write = (cls == C_LW) ? 2'b10 : 2'b01;
                    state_d          = S_FETCH;
                end
            end
            S_HALT: bus.halt = 1'b1;
            default: state_d = S_HALT;
        endcase
        // Asynchronous reset kills every strobe immediately, including FETCH's ir_write.
        if (!reset) begin
            bus.pc_write   = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.mem_read   = 1'b0;
            bus.mem_write  = 1'b0;
            bus.instr_done = 1'b0;
            bus.halt       = 1'b0;
        end
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: randomized instructions checked cycle by cycle
// against an instruction-level reference model, on two instances
// (default memory timeout of 15 and a short timeout of 4).
module tb_mc_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mc_ctrl_if if_a ();
    mc_ctrl_if if_b ();

    mc_ctrl #(.MEM_WAIT_MAX(15)) dut_a (.clock(clock), .reset(reset), .bus(if_a.master));
    mc_ctrl #(.MEM_WAIT_MAX(4))  dut_b (.clock(clock), .reset(reset), .bus(if_b.master));

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] vec;
        logic        rdy;
    } rec_t;
    rec_t exp_q[$];

    localparam int K_ILL = 0, K_R = 1, K_JR = 2, K_ADDI = 3, K_ORI = 4, K_LUI = 5,
                   K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10;

    logic [5:0] leg_op    [14] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd8, 6'd13,
                                   6'd15, 6'd35, 6'd43, 6'd4, 6'd2, 6'd3};
    logic [5:0] leg_funct [14] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd8, 6'd0, 6'd0,
                                   6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] funct);
        if (op == 6'd0) begin
            if (funct == 6'd32 || funct == 6'd34 || funct == 6'd36 ||
                funct == 6'd37 || funct == 6'd42) return K_R;
            if (funct == 6'd8) return K_JR;
            return K_ILL;
        end
        if (op == 6'd8)  return K_ADDI;
        if (op == 6'd13) return K_ORI;
        if (op == 6'd15) return K_LUI;
        if (op == 6'd35) return K_LW;
        if (op == 6'd43) return K_SW;
        if (op == 6'd4)  return K_BEQ;
        if (op == 6'd2)  return K_J;
        if (op == 6'd3)  return K_JAL;
        return K_ILL;
    endfunction

    // {aluop, s_ext, s_a, s_b} for instructions that use the ALU
    function automatic logic [7:0] alu_sel(input int k, input logic [5:0] funct);
        logic [3:0] a;
        case (k)
            K_R: begin
                a = (funct == 6'd32) ? 4'd0 : (funct == 6'd34) ? 4'd1 :
                    (funct == 6'd36) ? 4'd2 : (funct == 6'd37) ? 4'd3 : 4'd4;
                return {a, 2'b00, 1'b1, 1'b0};
            end
            K_ADDI:      return {4'd0, 2'b01, 1'b1, 1'b1};
            K_ORI:       return {4'd3, 2'b00, 1'b1, 1'b1};
            K_LUI:       return {4'd5, 2'b10, 1'b1, 1'b1};
            K_LW, K_SW:  return {4'd0, 2'b01, 1'b1, 1'b1};
            K_BEQ:       return {4'd0, 2'b11, 1'b0, 1'b1};
            default:     return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] pk(input logic [2:0] st, input bit pcw, input bit irw,
                                       input bit rw, input bit mr, input bit mw,
                                       input logic [7:0] alu, input logic [1:0] snw,
                                       input logic [1:0] sdw, input logic [1:0] snpc,
                                       input bit done, input bit hlt);
        return {8'h00, st, pcw, irw, rw, mr, mw, alu[7:4], snw, alu[3:2], alu[1], alu[0],
                sdw, snpc, done, hlt};
    endfunction

    function automatic logic [31:0] obs(input int sel);
        if (sel == 0)
            return {8'h00, if_a.state, if_a.pc_write, if_a.ir_write, if_a.reg_write,
                    if_a.mem_read, if_a.mem_write, if_a.aluop, if_a.s_num_write, if_a.s_ext,
                    if_a.s_a, if_a.s_b, if_a.s_data_write, if_a.s_npc, if_a.instr_done,
                    if_a.halt};
        return {8'h00, if_b.state, if_b.pc_write, if_b.ir_write, if_b.reg_write,
                if_b.mem_read, if_b.mem_write, if_b.aluop, if_b.s_num_write, if_b.s_ext,
                if_b.s_a, if_b.s_b, if_b.s_data_write, if_b.s_npc, if_b.instr_done,
                if_b.halt};
    endfunction

    function automatic void push(input logic [31:0] v, input logic r);
        rec_t e;
        e.vec = v;
        e.rdy = r;
        exp_q.push_back(e);
    endfunction

    // Builds the expected per-cycle trace of one instruction; returns 1 if it ends in HALT.
    function automatic bit build(input logic [5:0] op, input logic [5:0] funct, input bit z,
                                 input int nwait, input int limit);
        int k = classify(op, funct);
        logic [7:0] a = alu_sel(k, funct);
        exp_q.delete();
        push(pk(3'd0, 0, 1, 0, 0, 0, 8'h0, 2'd0, 2'd0, 2'd0, 0, 0), 1'b0);
        if (k == K_ILL) begin
            push(pk(3'd1, 0, 0, 0, 0, 0, 8'h0, 2'd0, 2'd0, 2'd0, 0, 0), 1'b0);
            for (int i = 0; i < 10; i++)
                push(pk(3'd7, 0, 0, 0, 0, 0, 8'h0, 2'd0, 2'd0, 2'd0, 0, 1), 1'b0);
            return 1'b1;
        end
        if (k == K_J)   begin push(pk(3'd1, 1, 0, 0, 0, 0, 8'h0, 2'd0, 2'd0, 2'd1, 1, 0), 1'b0); return 1'b0; end
        if (k == K_JAL) begin push(pk(3'd1, 1, 0, 1, 0, 0, 8'h0, 2'd2, 2'd0, 2'd1, 1, 0), 1'b0); return 1'b0; end
        if (k == K_JR)  begin push(pk(3'd1, 1, 0, 0, 0, 0, 8'h0, 2'd0, 2'd0, 2'd2, 1, 0), 1'b0); return 1'b0; end
        push(pk(3'd1, 0, 0, 0, 0, 0, 8'h0, 2'd0, 2'd0, 2'd0, 0, 0), 1'b0);
        if (k == K_BEQ) begin
            push(pk(3'd2, 1, 0, 0, 0, 0, a, 2'd0, 2'd0, z ? 2'd3 : 2'd0, 1, 0), 1'b0);
            return 1'b0;
        end
        push(pk(3'd2, 0, 0, 0, 0, 0, a, 2'd0, 2'd0, 2'd0, 0, 0), 1'b0);
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i < nwait; i++) begin
                if (limit != 0 && i + 1 == limit) begin
                    push(pk(3'd3, 0, 0, 0, 0, 0, a, 2'd0, 2'd0, 2'd0, 0, 0), 1'b0);
                    for (int h = 0; h < 5; h++)
                        push(pk(3'd7, 0, 0, 0, 0, 0, 8'h0, 2'd0, 2'd0, 2'd0, 0, 1), 1'b0);
                    return 1'b1;
                end
                push(pk(3'd3, 0, 0, 0, k == K_LW, k == K_SW, a, 2'd0, 2'd0, 2'd0, 0, 0), 1'b0);
            end
            if (k == K_SW) begin
                push(pk(3'd3, 1, 0, 0, 0, 1, a, 2'd0, 2'd0, 2'd0, 1, 0), 1'b1);
                return 1'b0;
            end
            push(pk(3'd3, 0, 0, 0, 1, 0, a, 2'd0, 2'd0, 2'd0, 0, 0), 1'b1);
            push(pk(3'd4, 1, 0, 1, 0, 0, a, 2'd0, 2'd2, 2'd0, 1, 0), 1'b0);
            return 1'b0;
        end
        push(pk(3'd4, 1, 0, 1, 0, 0, a, (k == K_R) ? 2'd1 : 2'd0, 2'd1, 2'd0, 1, 0), 1'b0);
        return 1'b0;
    endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] funct, input bit z, input logic rdy);
        if_a.op = op;  if_a.funct = funct;  if_a.zero = z;  if_a.mem_ready = rdy;
        if_b.op = op;  if_b.funct = funct;  if_b.zero = z;  if_b.mem_ready = rdy;
    endtask

    // Called just after a rising edge; leaves just after a rising edge with reset released.
    task automatic do_reset(input int sel);
        reset = 1'b0;
        #1;
        check("reset_async", obs(sel), 32'h0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold", obs(sel), 32'h0);
        reset = 1'b1;
    endtask

    task automatic run_instr(input int sel, input string name, input logic [5:0] op,
                             input logic [5:0] funct, input bit z, input int nwait);
        bit halted = build(op, funct, z, nwait, (sel == 0) ? 15 : 4);
        int len = exp_q.size();
        for (int i = 0; i < len; i++) begin
            drive(op, funct, z, exp_q[i].rdy);
            @(negedge clock);
            check($sformatf("%s c%0d/%0d", name, i, len), obs(sel), exp_q[i].vec);
            @(posedge clock);
            #1;
        end
        if (halted) do_reset(sel);
    endtask

    task automatic run_random(input int sel, input int count, input int wmax);
        logic [5:0] op, funct;
        int r;
        for (int n = 0; n < count; n++) begin
            r = $urandom_range(0, 15);
            if (r < 14) begin
                op    = leg_op[r];
                funct = leg_funct[r];
            end else begin
                op    = 6'($urandom_range(0, 63));
                funct = 6'($urandom_range(0, 63));
                for (int t = 0; t < 64 && classify(op, funct) != K_ILL; t++)
                    op = 6'($urandom_range(0, 63));
                if (classify(op, funct) != K_ILL) op = 6'd63;
            end
            run_instr(sel, $sformatf("rnd%0d op=%0d f=%0d", n, op, funct), op, funct,
                      1'($urandom_range(0, 1)), int'($urandom_range(0, wmax)));
        end
    endtask

    initial begin
        drive(6'd0, 6'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;

        // Default-timeout instance
        do_reset(0);
        run_instr(0, "add",      6'd0,  6'd32, 1'b0, 0);
        run_instr(0, "lw_w3",    6'd35, 6'd0,  1'b0, 3);
        run_instr(0, "sw_w0",    6'd43, 6'd0,  1'b0, 0);
        run_instr(0, "beq_z1",   6'd4,  6'd0,  1'b1, 0);
        run_instr(0, "beq_z0",   6'd4,  6'd0,  1'b0, 0);
        run_instr(0, "jal",      6'd3,  6'd0,  1'b0, 0);
        run_instr(0, "jr",       6'd0,  6'd8,  1'b0, 0);
        run_instr(0, "lui",      6'd15, 6'd0,  1'b0, 0);
        run_instr(0, "ill_op63", 6'd63, 6'd0,  1'b0, 0);
        run_instr(0, "lw_w14",   6'd35, 6'd0,  1'b0, 14);
        run_instr(0, "sw_w15",   6'd43, 6'd0,  1'b0, 15);

        // Reset asserted mid-MEM of a lw, away from any clock edge
        drive(6'd35, 6'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #2;
        check("lw_mem_before_rst", obs(0),
              pk(3'd3, 0, 0, 0, 1, 0, alu_sel(K_LW, 6'd0), 2'd0, 2'd0, 2'd0, 0, 0));
        reset = 1'b0;
        #1;
        check("lw_mem_async_rst", obs(0), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        run_instr(0, "after_rst_or", 6'd0, 6'd37, 1'b0, 0);

        run_random(0, 40, 5);

        // Short-timeout instance
        @(posedge clock);
        #1;
        do_reset(1);
        run_instr(1, "b_sw_stuck", 6'd43, 6'd0, 1'b0, 20);
        run_instr(1, "b_lw_w3",    6'd35, 6'd0, 1'b0, 3);
        run_instr(1, "b_lw_stuck", 6'd35, 6'd0, 1'b0, 4);
        run_instr(1, "b_addi",     6'd8,  6'd0, 1'b0, 0);
        run_random(1, 40, 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
